// File: rtl/main_fsm_pkg.sv
// main_fsm_pkg: state codes, opcodes and control-field encodings shared by the
// multicycle control FSM, the instruction decoder and the ALU decoder.
package main_fsm_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECUTER = 4'd6;
    localparam state_t S_EXECUTEI = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BEQ      = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_LUI      = 4'd11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/main_fsm.sv
// main_fsm: Moore control FSM for a multicycle RISC-V datapath; every control
// output decodes from the state register alone.
module main_fsm
    import main_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    output logic       IRWrite,
    output logic       PCUpdate,
    output logic       Branch,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ResultSrc,
    output logic [3:0] state
);

    state_t state_q, state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // op is only consulted in DECODE and MEMADR; unsupported ops fall back to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state_q)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.pc_update  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  ctrl.adr_src = 1'b1;
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    ctrl.reg_write = 1'b1;
            S_BEQ: begin
                ctrl.alu_src_a = SRCA_RD1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.branch    = 1'b1;
            end
            S_JAL: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_update = 1'b1;
            end
            S_LUI: begin
                ctrl.result_src = RES_IMMEXT;
                ctrl.reg_write  = 1'b1;
            end
            default:    ctrl = CTRL_IDLE;
        endcase
    end

    assign IRWrite   = ctrl.ir_write;
    assign PCUpdate  = ctrl.pc_update;
    assign Branch    = ctrl.branch;
    assign RegWrite  = ctrl.reg_write;
    assign MemWrite  = ctrl.mem_write;
    assign AdrSrc    = ctrl.adr_src;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOp     = ctrl.alu_op;
    assign ResultSrc = ctrl.result_src;
    assign state     = state_q;

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 op  input  7  opcode field from the instruction register (same field the instruction decoder receives).
REQ-004 IRWrite  output  1  load instruction register.
REQ-005 PCUpdate  output  1  unconditional PC load.
REQ-006 Branch  output  1  conditional PC load, qualified by Zero outside this block.
REQ-007 RegWrite  output  1  register file write enable.
REQ-008 MemWrite  output  1  data memory write enable.
REQ-009 AdrSrc  output  1  memory address select: 0=PC, 1=Result.
REQ-010 ALUSrcA  output  2  ALU A select: 00=PC, 01=OldPC, 10=RD1.
REQ-011 ALUSrcB  output  2  ALU B select: 00=RD2/WriteData, 01=ImmExt, 10=constant 4.
REQ-012 ALUOp  output  2  to ALU decoder: 00=add, 01=subtract/compare, 10=funct-decoded.
REQ-013 ResultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt.
REQ-014 state  output  4  current state code, for debug and verification only.

Function
REQ-015 The block SHALL be a Moore FSM: all outputs decode from the state register only, with no combinational path from op to any output.
REQ-016 States and codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, LUI=11; codes 12-15 are illegal.
REQ-017 The FSM SHALL take these transitions:
- FETCH -> DECODE.
- DECODE on op 0000011 or 0100011 -> MEMADR.
- DECODE on op 0110011 -> EXECUTER.
- DECODE on op 0010011 -> EXECUTEI.
- DECODE on op 1100011 -> BEQ.
- DECODE on op 1101111 -> JAL.
- DECODE on op 0110111 -> LUI.
REQ-018 The FSM SHALL also take these transitions:
- MEMADR -> MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD -> MEMWB.
- EXECUTER and EXECUTEI -> ALUWB.
- JAL -> ALUWB.
- MEMWB, MEMWRITE, ALUWB, BEQ and LUI -> FETCH.
REQ-019 An unsupported op in DECODE SHALL return to FETCH with no register or memory write (acts as NOP).
REQ-020 Illegal state codes SHALL go to FETCH on the next edge, with all outputs held at their defaults.
REQ-021 Per-state outputs SHALL be as follows; every output not listed is 0:
- FETCH: IRWrite=1, PCUpdate=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=01.
- MEMADR: ALUSrcA=10, ALUSrcB=01.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1.
- EXECUTER: ALUSrcA=10, ALUOp=10.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB: RegWrite=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
- LUI: ResultSrc=11, RegWrite=1.
REQ-022 Instruction latencies, counted from entry to FETCH, SHALL be: lw 5 cycles; sw 4; R-type 4; I-type 4; jal 4; beq 3; lui 3; unsupported op 2.
REQ-023 op SHALL be sampled only in DECODE and MEMADR; changes to op in any other state SHALL have no effect.
REQ-024 At most one of RegWrite and MemWrite SHALL be asserted in any cycle.
REQ-025 IRWrite SHALL be asserted only in FETCH.

Reset
REQ-026 While reset_n=0, state SHALL be FETCH asynchronously, and outputs SHALL therefore show FETCH values.
REQ-027 Assertion mid-instruction (e.g. in MEMWRITE) SHALL abort the instruction immediately, with no further writes.
REQ-028 The first rising clk edge after reset_n rises SHALL move FETCH -> DECODE.

Structure
REQ-029 A shared package SHALL hold the state enumeration (4-bit), the opcode constants (LOAD, STORE, RTYPE, ITYPE, BRANCH, JAL, LUI) and the ALUOp/ResultSrc/ALUSrc encodings, so the instruction decoder and ALU decoder use the same constants.
REQ-030 There SHALL be no sub-modules: one state register, a next-state case block and an output case block.

Verification
REQ-031 Release reset, hold op=0000011 -> states 0,1,2,3,4,0; RegWrite=1 only in state 4; AdrSrc=1 in state 3.
REQ-032 op=0100011 -> states 0,1,2,5,0; MemWrite=1 for exactly one cycle; RegWrite never asserted.
REQ-033 op=1100011, then op=0110111 -> 0,1,9 with Branch=1 and ALUOp=01; then 0,1,11 with ResultSrc=11 and RegWrite=1.
REQ-034 op=1101111 -> 0,1,10,8,0; PCUpdate=1 in states 0 and 10; RegWrite=1 in state 8.
REQ-035 op=1111111 in DECODE -> next state 0; no RegWrite, MemWrite or Branch asserted.
REQ-036 Run the 22-op program sequence (addi, or, and, add, beq, slt, sw, lw, jal, lui ...); pull reset_n low asynchronously during MEMWRITE -> state=0 and MemWrite=0 within the same cycle, with no clock edge needed.
